// File: rtl/memory_pkg.sv
// Shared definitions for the write buffer slice.
// Holds the default buffer depth, the drain FSM state encodings and the
// buffered entry layout used by write_buffer and wb_fifo.
package memory_pkg;

    localparam int unsigned WB_DEPTH_DEFAULT = 4;

    // Drain FSM encodings; kept as plain constants for legacy tooling.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_if.sv
// Bus bundle between the cache controller / SRAM controller side and the
// write buffer.
//   store side : wr_req_in, wr_addr_in, wr_data_in -> full_out, empty_out
//   fill side  : rd_req_in, rd_addr_in             -> rd_grant_out
//   SRAM side  : sram_ready_in -> sram_wr_en_out, sram_addr_out, sram_wdata_out
// Modport slave is the write buffer; master is whatever drives it.
interface write_buffer_if;

    logic        wr_req_in;
    logic [31:0] wr_addr_in;
    logic [31:0] wr_data_in;
    logic        full_out;
    logic        rd_req_in;
    logic [31:0] rd_addr_in;
    logic        rd_grant_out;
    logic        sram_wr_en_out;
    logic [31:0] sram_addr_out;
    logic [31:0] sram_wdata_out;
    logic        sram_ready_in;
    logic        empty_out;

    modport master (
        output wr_req_in, wr_addr_in, wr_data_in, rd_req_in, rd_addr_in, sram_ready_in,
        input  full_out, rd_grant_out, sram_wr_en_out, sram_addr_out, sram_wdata_out,
               empty_out
    );

    modport slave (
        input  wr_req_in, wr_addr_in, wr_data_in, rd_req_in, rd_addr_in, sram_ready_in,
        output full_out, rd_grant_out, sram_wr_en_out, sram_addr_out, sram_wdata_out,
               empty_out
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular store FIFO for the write buffer.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_addr/data  enqueue one entry (caller guarantees !full)
//   pop                   dequeue the head (caller guarantees !empty)
//   head_addr, head_data  current head entry
//   full, empty           occupancy flags derived from the registered count
//   entry_addr, entry_valid  per-slot address and valid bit for hazard checks
module wb_fifo
    import memory_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [31:0]            push_addr,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic [31:0]            head_addr,
    output logic [31:0]            head_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0][31:0] entry_addr,
    output logic [DEPTH-1:0]       entry_valid
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + CntW'(1);
        if (!push && pop) count_d = count_q - CntW'(1);
    end

    // Push and pop never hit the same slot: that would need count 0 (no pop)
    // or count DEPTH (push refused).
    always_comb begin
        valid_d = valid_q;
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Storage carries no reset; stale slots are masked by valid_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: push_addr, data: push_data};
    end

    assign head_addr   = mem_q[rd_ptr_q].addr;
    assign head_data   = mem_q[rd_ptr_q].data;
    assign full        = (count_q == CntW'(DEPTH));
    assign empty       = (count_q == '0);
    assign entry_valid = valid_q;

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
        assign entry_addr[i] = mem_q[i].addr;
    end

endmodule

// File: rtl/write_buffer.sv
// Store write buffer between the cache controller and the SRAM controller.
// Buffers stores in wb_fifo and drains them one at a time (IDLE -> DRAIN ->
// GAP) while letting line-fill reads bypass unless they hit a buffered line.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        write_buffer_if.slave (store, fill and SRAM handshakes)
//   stall_cnt_out, drain_cnt_out  only with WRITE_BUFFER_STATS_EN defined:
//              cycles a store was held off by full, and completed pops.
module write_buffer
    import memory_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    write_buffer_if.slave bus
`ifdef WRITE_BUFFER_STATS_EN
    ,
    output logic [31:0]   stall_cnt_out,
    output logic [31:0]   drain_cnt_out
`endif
);

    logic                   push, pop;
    logic [31:0]            head_addr, head_data;
    logic                   full, empty;
    logic [DEPTH-1:0][31:0] entry_addr;
    logic [DEPTH-1:0]       entry_valid;
    logic                   hazard;
    logic                   in_drain;
    logic [1:0]             state_q, state_d;
    logic                   unused_bits;

    // A push at full is refused even if the head pops this same cycle.
    assign push = bus.wr_req_in & ~full;
    assign pop  = in_drain & bus.sram_ready_in;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (bus.wr_addr_in),
        .push_data   (bus.wr_data_in),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (full),
        .empty       (empty),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // Read-after-write hazard: fill address in the same 8-byte line as any
    // buffered store.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entry_valid[i] && (entry_addr[i][31:3] == bus.rd_addr_in[31:3])) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        unused_bits = ^bus.rd_addr_in[2:0];
        for (int i = 0; i < int'(DEPTH); i++) begin
            unused_bits = unused_bits ^ (^entry_addr[i][2:0]);
        end
    end

    // A pending non-hazard read blocks the drain start, so grant and
    // sram_wr_en_out are never high together.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty && (!bus.rd_req_in || hazard)) state_d = DRAIN;
            DRAIN:   if (bus.sram_ready_in) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign in_drain           = (state_q == DRAIN);
    assign bus.sram_wr_en_out = in_drain;
    assign bus.sram_addr_out  = in_drain ? head_addr : '0;
    assign bus.sram_wdata_out = in_drain ? head_data : '0;
    assign bus.rd_grant_out   = (state_q == IDLE) & bus.rd_req_in & ~hazard;
    assign bus.full_out       = full;
    assign bus.empty_out      = empty;

`ifdef WRITE_BUFFER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_out <= '0;
            drain_cnt_out <= '0;
        end else begin
            if (bus.wr_req_in && full) stall_cnt_out <= stall_cnt_out + 32'd1;
            if (pop)                   drain_cnt_out <= drain_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have wr_req_in  input  1  store request from the cache controller (one word per cycle).
REQ-005 SHALL have wr_addr_in  input  32  store byte address.
REQ-006 SHALL have wr_data_in  input  32  store data.
REQ-007 SHALL have full_out  output  1  buffer full; a store is not accepted this cycle.
REQ-008 SHALL have rd_req_in  input  1  cache-miss line-fill request.
REQ-009 SHALL have rd_addr_in  input  32  line-fill byte address.
REQ-010 SHALL have rd_grant_out  output  1  line fill may be issued to the SRAM controller this cycle.
REQ-011 SHALL have sram_wr_en_out  output  1  write request to the SRAM controller.
REQ-012 SHALL have sram_addr_out  output  32  address of the head entry.
REQ-013 SHALL have sram_wdata_out  output  32  data of the head entry.
REQ-014 SHALL have sram_ready_in  input  1  SRAM controller done pulse (one cycle).
REQ-015 SHALL have empty_out  output  1  no buffered stores.

Function
REQ-016 SHALL be a circular FIFO: write pointer, read pointer, count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-017 SHALL accept a store on a rising edge when wr_req_in=1 and full_out=0; a store while full is ignored and the requester holds.
REQ-018 SHALL, on a simultaneous push and pop, perform both with count unchanged; push at full with a pop in the same cycle is still refused (full_out is registered from count).
REQ-019 SHALL use drain FSM states IDLE, DRAIN, GAP.
REQ-020 SHALL go IDLE->DRAIN when not empty and (rd_req_in=0 or a hazard from REQ-024 exists).
REQ-021 SHALL assert sram_wr_en_out only in DRAIN, with sram_addr_out/sram_wdata_out equal to the head entry, stable until sram_ready_in.
REQ-022 SHALL, in DRAIN with sram_ready_in=1, pop the head and go to GAP.
REQ-023 SHALL hold sram_wr_en_out=0 in GAP for exactly one cycle, so the controller returns to idle, then go to IDLE.
REQ-024 SHALL define a hazard as rd_addr_in[31:3] matching addr[31:3] of any valid entry (same 8-byte line).
REQ-025 SHALL assert rd_grant_out combinationally when state=IDLE and rd_req_in=1 and no hazard; with a hazard, reads wait until the matching entries drain.
REQ-026 SHALL never assert rd_grant_out and sram_wr_en_out in the same cycle.
REQ-027 SHALL keep the IDLE->DRAIN decision stable while rd_grant_out=1: no drain starts while a granted read is pending.

Reset
REQ-028 SHALL, on rst, clear pointers and count, set state IDLE, full_out=0, empty_out=1, sram_wr_en_out=0, rd_grant_out=0, sram_addr_out=0, sram_wdata_out=0.
REQ-029 SHALL abandon an in-flight SRAM write on rst mid-DRAIN; entry contents are lost.

Configuration
REQ-030 SHALL support macro WRITE_BUFFER_STATS_EN: when defined, add outputs stall_cnt_out[31:0] (cycles with wr_req_in=1 and full_out=1) and drain_cnt_out[31:0] (completed pops), both reset to 0 and wrapping at 2^32.
REQ-031 SHALL, without WRITE_BUFFER_STATS_EN, omit both counters and ports, with all other behaviour identical.

Structure
REQ-032 SHALL place FSM state encodings (IDLE=0, DRAIN=1, GAP=2, 2 bits) and the DEPTH default in a shared package, memory_pkg.
REQ-033 SHALL implement storage plus pointers as sub-module wb_fifo (push, pop, head, full, empty, per-entry address/valid vector for the hazard compare); the FSM and arbitration stay in write_buffer.

Verification
REQ-034 SHALL cover: reset, then push 0x400/0xDEADBEEF -> DRAIN next cycle, sram_addr_out=0x400, sram_wdata_out=0xDEADBEEF; ready pulse -> empty_out=1; one GAP cycle with sram_wr_en_out=0.
REQ-035 SHALL cover: 5 pushes with DEPTH=4 and sram_ready_in held 0 -> full_out=1 after the 4th; 5th ignored; drain order matches push order.
REQ-036 SHALL cover: entry at 0x408 buffered, rd_req_in with rd_addr_in=0x40C -> rd_grant_out=0 until the 0x408 entry pops; then grant in the first IDLE cycle.
REQ-037 SHALL cover: rd_req_in at 0x800 with a non-matching entry buffered, state IDLE -> rd_grant_out=1 immediately; no drain starts while the request is held.
REQ-038 SHALL cover: full buffer with push and ready pulse in the same cycle -> push refused, count becomes 3, full_out=0 next cycle.
REQ-039 SHALL cover: rst asserted mid-DRAIN -> all outputs at reset values asynchronously; with WRITE_BUFFER_STATS_EN, counters read 0.
